// File: rtl/pb_step_if.sv
// pb_step_if: button-side inputs and CPU-enable outputs of the run/step controller
interface pb_step_if;
    logic        step_down;
    logic        step_state;
    logic        run_toggle;
    logic        halt;
    logic        cpu_ce;
    logic        running;
    logic        auto_rep;
    logic [15:0] step_cnt;
    modport master (
        output step_down, step_state, run_toggle, halt,
        input  cpu_ce, running, auto_rep, step_cnt
    );
    modport slave (
        input  step_down, step_state, run_toggle, halt,
        output cpu_ce, running, auto_rep, step_cnt
    );
endinterface

// File: rtl/pb_step_ctrl.sv
// pb_step_ctrl: turns debounced step/run buttons into the CPU clock enable
module pb_step_ctrl #(
    parameter int HOLD_CYCLES   = 12_000_000,
    parameter int REPEAT_CYCLES = 3_000_000,
    parameter int RUN_DIV       = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    pb_step_if.slave  bus
);
    localparam int M1 = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int MX = M1 > RUN_DIV ? M1 : RUN_DIV;
    localparam int CW = $clog2(MX + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_DIV - 1);
    typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT, RUN} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ce, ce_nxt;
    logic          running, auto_rep;
    logic [15:0]   step_cnt;
    // next state, counter and enable; halt beats run_toggle beats step_down beats counters
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        ce_nxt    = 1'b0;
        if (bus.halt) begin
            state_nxt = IDLE;
        end else if (bus.run_toggle) begin
            state_nxt = state == RUN ? IDLE : RUN;
            ce_nxt    = state != RUN;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = bus.step_down ? HOLD_WAIT : IDLE;
                    ce_nxt    = bus.step_down;
                end
                HOLD_WAIT: begin
                    state_nxt = !bus.step_state ? IDLE : cnt == HOLD_LAST ? REPEAT : HOLD_WAIT;
                    ce_nxt    = bus.step_state && cnt == HOLD_LAST;
                    cnt_nxt   = bus.step_state && cnt != HOLD_LAST ? cnt + CW'(1) : '0;
                end
                REPEAT: begin
                    state_nxt = bus.step_state ? REPEAT : IDLE;
                    ce_nxt    = bus.step_state && cnt == REP_LAST;
                    cnt_nxt   = bus.step_state && cnt != REP_LAST ? cnt + CW'(1) : '0;
                end
                default: begin
                    ce_nxt    = cnt == RUN_LAST;
                    cnt_nxt   = cnt == RUN_LAST ? '0 : cnt + CW'(1);
                end
            endcase
        end
    end
    // register state and all outputs; step_cnt advances together with cpu_ce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ce       <= 1'b0;
            running  <= 1'b0;
            auto_rep <= 1'b0;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ce       <= ce_nxt;
            running  <= state_nxt == RUN;
            auto_rep <= state_nxt == REPEAT;
            step_cnt <= step_cnt + 16'(ce_nxt);
        end
    end
    assign bus.cpu_ce   = ce;
    assign bus.running  = running;
    assign bus.auto_rep = auto_rep;
    assign bus.step_cnt = step_cnt;
endmodule

// File: tb/tb_pb_step_ctrl.sv
// tb_pb_step_ctrl: scoreboard bench for two controllers (RUN_DIV=1 and RUN_DIV=3)
module tb_pb_step_ctrl;
    localparam int H = 8;
    localparam int R = 4;
    typedef struct packed {
        logic        ce;
        logic        run;
        logic        ar;
        logic [15:0] cnt;
    } exp_t;
    typedef struct packed {
        exp_t d0;
        exp_t d1;
    } pair_t;
    typedef enum {M_IDLE, M_STEP, M_RUN} mode_t;

    logic clk = 0, rst_n = 0, rst_req = 0;
    logic step_down = 0, step_state = 0, run_toggle = 0, halt = 0;
    int   checks = 0, errors = 0;
    pair_t q[$];

    mode_t       mode[2];
    int          age[2];
    logic        mce[2];
    logic [15:0] sc[2];
    int          div[2] = '{1, 3};

    always #5 clk = ~clk;

    pb_step_if b0 ();
    pb_step_if b1 ();
    assign b0.step_down  = step_down;
    assign b0.step_state = step_state;
    assign b0.run_toggle = run_toggle;
    assign b0.halt       = halt;
    assign b1.step_down  = step_down;
    assign b1.step_state = step_state;
    assign b1.run_toggle = run_toggle;
    assign b1.halt       = halt;

    pb_step_ctrl #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .RUN_DIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0.slave));
    pb_step_ctrl #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .RUN_DIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    function automatic exp_t got(input int i);
        return i == 0 ? exp_t'({b0.cpu_ce, b0.running, b0.auto_rep, b0.step_cnt})
                      : exp_t'({b1.cpu_ce, b1.running, b1.auto_rep, b1.step_cnt});
    endfunction

    task automatic chk(input string name, input exp_t g, input exp_t e);
        checks++;
        if (g !== e) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s t=%0t got ce=%b run=%b ar=%b cnt=%h required ce=%b run=%b ar=%b cnt=%h",
                         name, $time, g.ce, g.run, g.ar, g.cnt, e.ce, e.run, e.ar, e.cnt);
        end
    endtask

    // reference: pulses derived from time since press / run entry
    task automatic model_step();
        exp_t e[2];
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mode[i] = M_IDLE; age[i] = 0; mce[i] = 0; sc[i] = 0;
            end else begin
                if (halt) begin
                    mode[i] = M_IDLE; mce[i] = 0;
                end else if (run_toggle) begin
                    if (mode[i] == M_RUN) begin
                        mode[i] = M_IDLE; mce[i] = 0;
                    end else begin
                        mode[i] = M_RUN; age[i] = 0; mce[i] = 1;
                    end
                end else if (mode[i] == M_IDLE) begin
                    mce[i] = step_down;
                    if (step_down) begin
                        mode[i] = M_STEP; age[i] = 0;
                    end
                end else if (mode[i] == M_STEP) begin
                    if (!step_state) begin
                        mode[i] = M_IDLE; mce[i] = 0;
                    end else begin
                        age[i]++;
                        mce[i] = age[i] >= H && (age[i] - H) % R == 0;
                    end
                end else begin
                    age[i]++;
                    mce[i] = age[i] % div[i] == 0;
                end
                sc[i] = sc[i] + 16'(mce[i]);
            end
            e[i] = '{mce[i], mode[i] == M_RUN, mode[i] == M_STEP && age[i] >= H, sc[i]};
        end
        q.push_back({e[0], e[1]});
    endtask

    task automatic cyc(input logic sd, input logic ss, input logic rt, input logic h);
        @(negedge clk);
        rst_n = rst_req; step_down = sd; step_state = ss; run_toggle = rt; halt = h;
        model_step();
    endtask

    task automatic async_reset();
        @(negedge clk);
        step_down = 0; step_state = 0; run_toggle = 0; halt = 0;
        #2 rst_n = 0; rst_req = 0;
        #1;
        chk("async_rst0", got(0), '0);
        chk("async_rst1", got(1), '0);
        model_step();
    endtask

    // monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                p = q.pop_front();
                chk("dut0", got(0), p.d0);
                chk("dut1", got(1), p.d1);
            end
        end
    end

    initial begin
        logic ss;
        repeat (3) cyc(0, 0, 0, 0);
        rst_req = 1;
        repeat (2) cyc(0, 0, 0, 0);
        // single step
        cyc(1, 1, 0, 0);
        repeat (2) cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // hold to auto-repeat then release
        cyc(1, 1, 0, 0);
        repeat (19) cyc(0, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        // run, step ignored, run off
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // halt while running, presses blocked, no resume
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        // step and run together in idle
        cyc(1, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // run_toggle abandons a step hold
        cyc(1, 1, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (4) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // asynchronous reset in REPEAT
        cyc(1, 1, 0, 0);
        repeat (12) cyc(0, 1, 0, 0);
        async_reset();
        repeat (2) cyc(0, 1, 0, 0);
        rst_req = 1;
        repeat (3) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);
        // random traffic
        ss = 0;
        for (int k = 0; k < 600; k++) begin
            logic sd, rt, h;
            sd = $urandom_range(0, 7) == 0;
            rt = $urandom_range(0, 24) == 0;
            h  = $urandom_range(0, 39) == 0;
            if (sd) ss = 1;
            else if ($urandom_range(0, 14) == 0) ss = 0;
            cyc(sd, ss, rt, h);
        end
        cyc(0, 0, 0, 1);
        // step_cnt wrap in free run
        cyc(0, 0, 1, 0);
        for (int k = 0; k < 70000 && sc[0] != 16'h0003; k++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
